// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner
//   Conditions the raw pedestrian push-button for the traffic-light cycle
//   counter. The pin is synchronized and debounced, and each debounced press
//   latches one request (ped_req). The request is held stable for a whole
//   light cycle and is cleared when the counter reports a wrap to zero.
//   Optional feature macro: PED_REQ_COUNT_EN adds a saturating count of served
//   requests on req_count; without it req_count is tied to zero.
module ped_request_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_raw,
  input  logic       cycle_wrap,
  output logic       ped_req,
  output logic       press_pulse,
  output logic       btn_level,
  output logic [7:0] req_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   btn_s;
  state_t                 state_r, state_nx_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
  logic                   level_r, level_nx_s;
  logic                   press_hit_r, press_hit_nx_s;
  logic                   press_pulse_r;
  logic                   ped_req_r;
  logic [7:0]             req_count_r;

  // Shift the asynchronous pin through the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign btn_s = sync_r[SYNC_STAGES-1];

  // Debounce state, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      level_r       <= 1'b0;
      press_hit_r   <= 1'b0;
      press_pulse_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      level_r       <= level_nx_s;
      press_hit_r   <= press_hit_nx_s;
      // The pulse trails the entry into PRESSED by one clock.
      press_pulse_r <= press_hit_r;
    end
  end

  // Debounce next-state: a level change needs DEBOUNCE_CYCLES equal samples.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    level_nx_s     = level_r;
    press_hit_nx_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn_s) begin
          state_nx_s = PRESS_WAIT;
          cnt_nx_s   = CNT_ONE;
        end else begin
          cnt_nx_s   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nx_s = IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_nx_s     = PRESSED;
          cnt_nx_s       = CNT_ZERO;
          level_nx_s     = 1'b1;
          press_hit_nx_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nx_s = RELEASE_WAIT;
          cnt_nx_s   = CNT_ONE;
        end else begin
          cnt_nx_s   = CNT_ZERO;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Bounce during release: back to PRESSED without a new pulse.
          state_nx_s = PRESSED;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_nx_s = IDLE;
          cnt_nx_s   = CNT_ZERO;
          level_nx_s = 1'b0;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
        level_nx_s = 1'b0;
      end
    endcase
  end

  // Request latch: a new press wins over a coincident wrap, so it is kept
  // for the next light cycle instead of being dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_req_r <= 1'b0;
    end else if (press_pulse_r) begin
      ped_req_r <= 1'b1;
    end else if (cycle_wrap && ped_req_r) begin
      ped_req_r <= 1'b0;
    end else begin
      ped_req_r <= ped_req_r;
    end
  end

`ifdef PED_REQ_COUNT_EN
  // Saturating count of served requests (wrap seen while a request is up).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_count_r <= 8'd0;
    end else if (cycle_wrap && ped_req_r && (req_count_r != 8'hFF)) begin
      req_count_r <= req_count_r + 8'd1;
    end else begin
      req_count_r <= req_count_r;
    end
  end
`else
  assign req_count_r = 8'd0;
`endif

  assign ped_req     = ped_req_r;
  assign press_pulse = press_pulse_r;
  assign btn_level   = level_r;
  assign req_count   = req_count_r;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// tb_ped_request_conditioner
//   Scoreboard bench: the cycle at which each press_pulse must appear is
//   pushed when the button edge is driven and popped when the pulse shows up.
//   Build with PED_REQ_COUNT_EN defined to exercise the served-request counter.
module tb_ped_request_conditioner;

  localparam int LAT = 19;

`ifdef PED_REQ_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
  localparam int SERVE_LOOPS = 260;
`else
  localparam bit COUNT_EN = 1'b0;
  localparam int SERVE_LOOPS = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_raw;
  logic       cycle_wrap;
  logic       ped_req;
  logic       press_pulse;
  logic       btn_level;
  logic [7:0] req_count;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         pulse_q[$];
  logic [7:0] exp_count = 8'd0;

  ped_request_conditioner dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .cycle_wrap  (cycle_wrap),
    .ped_req     (ped_req),
    .press_pulse (press_pulse),
    .btn_level   (btn_level),
    .req_count   (req_count)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Bench cycle counter, one per rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a clean rising edge and book the expected pulse cycle.
  task automatic press_btn();
    btn_raw = 1'b1;
    pulse_q.push_back(cyc + LAT);
  endtask

  task automatic note_serve();
    if (COUNT_EN && exp_count != 8'hFF) exp_count = exp_count + 8'd1;
  endtask

  // Scoreboard consumer: every observed pulse must match a booked cycle.
  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin
      if (pulse_q.size() == 0) begin
        check_val("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        check_val("pulse_cycle", cyc, pulse_q.pop_front());
      end
    end
  end

  // Run-time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    reset_n    = 1'b0;
    btn_raw    = 1'b0;
    cycle_wrap = 1'b0;
    tick(3);
    check_val("rst_ped_req", ped_req, 1'b0);
    check_val("rst_pulse", press_pulse, 1'b0);
    check_val("rst_level", btn_level, 1'b0);
    check_val("rst_count", req_count, 8'd0);
    reset_n = 1'b1;
    tick(2);

    // Clean press held 40 clocks.
    r = cyc;
    press_btn();
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (cyc == r + LAT) check_val("req_at_pulse", ped_req, 1'b0);
      if (cyc == r + LAT + 1) check_val("req_after_pulse", ped_req, 1'b1);
    end
    check_val("press_req_held", ped_req, 1'b1);
    check_val("press_level", btn_level, 1'b1);
    btn_raw = 1'b0;
    tick(25);
    check_val("release_level", btn_level, 1'b0);
    check_val("release_req_held", ped_req, 1'b1);

    // Serve the request with a single wrap pulse.
    cycle_wrap = 1'b1;
    tick(1);
    cycle_wrap = 1'b0;
    note_serve();
    check_val("serve_req", ped_req, 1'b0);
    check_val("serve_count", req_count, exp_count);

    // Bounce: 15 high, 3 low, then high long enough to qualify.
    btn_raw = 1'b1;
    tick(15);
    btn_raw = 1'b0;
    tick(3);
    press_btn();
    tick(15);
    check_val("bounce_no_req", ped_req, 1'b0);
    tick(10);
    check_val("bounce_then_req", ped_req, 1'b1);
    btn_raw = 1'b0;
    tick(25);

    // Press pulse coincident with wrap while a request is up: request stays.
    press_btn();
    tick(LAT);
    cycle_wrap = 1'b1;
    tick(1);
    cycle_wrap = 1'b0;
    note_serve();
    check_val("coinc_req_kept", ped_req, 1'b1);
    check_val("coinc_count", req_count, exp_count);
    btn_raw = 1'b0;
    tick(25);

    // Second press while a request is pending is absorbed.
    press_btn();
    tick(25);
    check_val("absorb_req", ped_req, 1'b1);
    btn_raw = 1'b0;
    tick(25);
    cycle_wrap = 1'b1;
    tick(3);
    cycle_wrap = 1'b0;
    note_serve();
    check_val("one_clear_req", ped_req, 1'b0);
    check_val("held_wrap_count", req_count, exp_count);

    // Asynchronous reset mid-clock with the button held and a request up.
    press_btn();
    tick(25);
    check_val("pre_reset_req", ped_req, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_req", ped_req, 1'b0);
    check_val("async_rst_level", btn_level, 1'b0);
    check_val("async_rst_count", req_count, 8'd0);
    exp_count = 8'd0;
    tick(3);
    reset_n = 1'b1;
    r = cyc;
    pulse_q.push_back(cyc + LAT);
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (cyc == r + LAT - 1) check_val("post_rst_no_req", ped_req, 1'b0);
    end
    check_val("post_rst_req", ped_req, 1'b1);
    btn_raw = 1'b0;
    cycle_wrap = 1'b1;
    tick(1);
    cycle_wrap = 1'b0;
    note_serve();
    tick(20);

    // Repeated serve events; saturates at 8'hFF when the counter is built.
    for (int k = 0; k < SERVE_LOOPS; k++) begin
      press_btn();
      tick(21);
      check_val("loop_req", ped_req, 1'b1);
      btn_raw = 1'b0;
      cycle_wrap = 1'b1;
      tick(1);
      cycle_wrap = 1'b0;
      note_serve();
      tick(20);
      check_val("loop_count", req_count, exp_count);
    end
    check_val("final_count", req_count, COUNT_EN ? 8'hFF : 8'd0);

    tick(5);
    check_val("pulse_q_empty", pulse_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
